// File: rtl/mcp3008_pkg.sv
// Shared types and frame constants for the MCP3008 SPI reader.
package mcp3008_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        GAP
    } state_t;

    localparam logic [4:0] FRAME_EDGES     = 5'd17;
    localparam logic [4:0] NULL_EDGE       = 5'd7;
    localparam logic [4:0] FIRST_DATA_EDGE = 5'd8;

    // DIN bit to drive after falling edge edge_num, for the ADC to latch on rising edge edge_num+1
    function automatic logic next_cmd_bit(
        input logic [4:0] edge_num,
        input logic       sgl,
        input logic [2:0] chan
    );
        logic b;
        case (edge_num)
            5'd1:    b = sgl;
            5'd2:    b = chan[2];
            5'd3:    b = chan[1];
            5'd4:    b = chan[0];
            default: b = 1'b0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/mcp3008_reader_spi_tick_gen.sv
// SCLK half-period divider: strobes rise_o/fall_o on the last cycle of each low/high half.
module spi_tick_gen #(
    parameter int SCLK_HALF = 675
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic rise_o,
    output logic fall_o
);
    localparam int CNT_W = $clog2(SCLK_HALF);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;
    logic             tick;

    always_comb begin
        tick    = en_i && (cnt_q == CNT_W'(SCLK_HALF - 1));
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (!en_i) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (tick) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign rise_o = tick && !phase_q;
    assign fall_o = tick && phase_q;

endmodule

// File: rtl/mcp3008_reader.sv
// MCP3008 SPI master: runs one 17-clock frame per accepted start_i and returns a 10-bit sample.
// All SPI timing is counted in clk cycles; MISO passes through a 2-FF synchroniser.
module mcp3008_reader
    import mcp3008_pkg::*;
#(
    parameter int SCLK_HALF = 675,
    parameter int CS_GAP    = 27
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic [2:0] chan_i,
    input  logic       single_ended_i,
    output logic       busy_o,
    output logic       valid_o,
    output logic [9:0] data_o,
    output logic [2:0] chan_o,
    output logic       null_err_o,
    output logic       sclk_o,
    output logic       cs_n_o,
    output logic       mosi_o,
    input  logic       miso_i
);
    localparam int GAP_W = $clog2(CS_GAP + 1);

    state_t           state_q, state_d;
    logic [4:0]       edge_cnt_q, edge_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [9:0]       shift_q, shift_d;
    logic [2:0]       chan_cap_q, chan_cap_d;
    logic             sgl_cap_q, sgl_cap_d;
    logic             null_q, null_d;
    logic             samp1_q, samp1_d;
    logic             samp2_q, samp2_d;
    logic             miso_s1_q, miso_s2_q;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic [9:0]       data_q, data_d;
    logic [2:0]       chan_q, chan_d;
    logic             null_err_q, null_err_d;
    logic             sclk_q, sclk_d;
    logic             cs_n_q, cs_n_d;
    logic             mosi_q, mosi_d;
    logic             rise, fall, tick_en;

    // The SETUP hold is the divider's first low half-period, so rising edge 1 ends SETUP
    assign tick_en = (state_q == SETUP) || (state_q == SHIFT);

    spi_tick_gen #(
        .SCLK_HALF(SCLK_HALF)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (tick_en),
        .rise_o (rise),
        .fall_o (fall)
    );

    always_comb begin
        state_d    = state_q;
        edge_cnt_d = edge_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        shift_d    = shift_q;
        chan_cap_d = chan_cap_q;
        sgl_cap_d  = sgl_cap_q;
        null_d     = null_q;
        samp1_d    = rise;
        samp2_d    = samp1_q;
        busy_d     = busy_q;
        valid_d    = 1'b0;
        data_d     = data_q;
        chan_d     = chan_q;
        null_err_d = null_err_q;
        sclk_d     = sclk_q;
        cs_n_d     = cs_n_q;
        mosi_d     = mosi_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    chan_cap_d = chan_i;
                    sgl_cap_d  = single_ended_i;
                    busy_d     = 1'b1;
                    cs_n_d     = 1'b0;
                    mosi_d     = 1'b1;
                    edge_cnt_d = '0;
                    shift_d    = '0;
                    null_d     = 1'b0;
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                if (rise) begin
                    sclk_d     = 1'b1;
                    edge_cnt_d = edge_cnt_q + 5'd1;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                if (rise) begin
                    sclk_d     = 1'b1;
                    edge_cnt_d = edge_cnt_q + 5'd1;
                end else if (fall) begin
                    sclk_d = 1'b0;
                    if (edge_cnt_q == FRAME_EDGES) begin
                        cs_n_d     = 1'b1;
                        mosi_d     = 1'b0;
                        valid_d    = 1'b1;
                        data_d     = shift_q;
                        chan_d     = chan_cap_q;
                        null_err_d = null_q;
                        gap_cnt_d  = '0;
                        state_d    = GAP;
                    end else begin
                        mosi_d = next_cmd_bit(edge_cnt_q, sgl_cap_q, chan_cap_q);
                    end
                end
                // Two cycles after a rising edge the synchronised MISO reflects that edge's bit
                if (samp2_q) begin
                    if (edge_cnt_q == NULL_EDGE) begin
                        null_d = miso_s2_q;
                    end else if (edge_cnt_q >= FIRST_DATA_EDGE) begin
                        shift_d = {shift_q[8:0], miso_s2_q};
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_W'(CS_GAP)) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            edge_cnt_q <= '0;
            gap_cnt_q  <= '0;
            shift_q    <= '0;
            chan_cap_q <= '0;
            sgl_cap_q  <= 1'b0;
            null_q     <= 1'b0;
            samp1_q    <= 1'b0;
            samp2_q    <= 1'b0;
            miso_s1_q  <= 1'b0;
            miso_s2_q  <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            chan_q     <= '0;
            null_err_q <= 1'b0;
            sclk_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            edge_cnt_q <= edge_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            shift_q    <= shift_d;
            chan_cap_q <= chan_cap_d;
            sgl_cap_q  <= sgl_cap_d;
            null_q     <= null_d;
            samp1_q    <= samp1_d;
            samp2_q    <= samp2_d;
            miso_s1_q  <= miso_i;
            miso_s2_q  <= miso_s1_q;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            chan_q     <= chan_d;
            null_err_q <= null_err_d;
            sclk_q     <= sclk_d;
            cs_n_q     <= cs_n_d;
            mosi_q     <= mosi_d;
        end
    end

    assign busy_o     = busy_q;
    assign valid_o    = valid_q;
    assign data_o     = data_q;
    assign chan_o     = chan_q;
    assign null_err_o = null_err_q;
    assign sclk_o     = sclk_q;
    assign cs_n_o     = cs_n_q;
    assign mosi_o     = mosi_q;

endmodule

// File: tb/tb_mcp3008_reader.sv
// Directed/randomised bench for mcp3008_reader with a cycle-sampled MCP3008 slave model.
module tb_mcp3008_reader;
    localparam int SH        = 4;
    localparam int GAP       = 3;
    localparam int FRAME_LEN = 1 + 34 * SH;
    localparam int PERIOD    = FRAME_LEN + GAP + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_i = 1'b0;
    logic [2:0] chan_i = 3'd0;
    logic       single_ended_i = 1'b0;
    logic       miso_i = 1'b0;
    logic       busy_o, valid_o, null_err_o, sclk_o, cs_n_o, mosi_o;
    logic [9:0] data_o;
    logic [2:0] chan_o;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    mcp3008_reader #(
        .SCLK_HALF(SH),
        .CS_GAP   (GAP)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_i),
        .chan_i        (chan_i),
        .single_ended_i(single_ended_i),
        .busy_o        (busy_o),
        .valid_o       (valid_o),
        .data_o        (data_o),
        .chan_o        (chan_o),
        .null_err_o    (null_err_o),
        .sclk_o        (sclk_o),
        .cs_n_o        (cs_n_o),
        .mosi_o        (mosi_o),
        .miso_i        (miso_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ADC model state and observation logs
    typedef struct {
        int         c;
        logic [9:0] d;
        logic [2:0] ch;
        logic       n;
    } vrec_t;

    logic [9:0] adc_val [8];
    logic       model_null = 1'b0;
    vrec_t      vq[$];
    int         rise_q[$];
    logic [4:0] cmd_q[$];
    int         gap_q[$];
    int         rule_viol = 0;

    initial begin : adc_model
        logic       prev_sclk, prev_cs, prev_mosi;
        int         rises, falls, last_rise_c;
        logic [4:0] cmd;
        logic [9:0] fval;
        logic       fnull;
        prev_sclk = 1'b0; prev_cs = 1'b1; prev_mosi = 1'b0;
        rises = 0; falls = 0; last_rise_c = -1;
        cmd = '0; fval = '0; fnull = 1'b0;
        forever begin
            @(negedge clk);
            if (valid_o === 1'b1) vq.push_back('{cyc, data_o, chan_o, null_err_o});
            if (prev_cs && !cs_n_o) begin
                rises = 0; falls = 0; cmd = '0;
                if (last_rise_c >= 0) gap_q.push_back(cyc - last_rise_c);
            end else if (!cs_n_o) begin
                if (mosi_o !== prev_mosi && !(prev_sclk && !sclk_o)) rule_viol++;
                if (!prev_sclk && sclk_o) begin
                    rises++;
                    if (rises <= 5) cmd = {cmd[3:0], mosi_o};
                    else if (mosi_o !== 1'b0) rule_viol++;
                    if (rises == 5) begin
                        cmd_q.push_back(cmd);
                        fval  = adc_val[cmd[2:0]];
                        fnull = model_null;
                    end
                end
                if (prev_sclk && !sclk_o) begin
                    falls++;
                    if (falls == 6) miso_i = fnull;
                    else if (falls >= 7 && falls <= 16) miso_i = fval[16 - falls];
                    else miso_i = 1'($urandom);
                end
            end
            if (!prev_cs && cs_n_o) begin
                rise_q.push_back(rises);
                last_rise_c = cyc;
                miso_i = 1'($urandom);
            end
            prev_cs = cs_n_o; prev_sclk = sclk_o; prev_mosi = mosi_o;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic wait_neg(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy_o !== 1'b0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", 32'(busy_o), 32'd0);
    endtask

    task automatic pulse_at(input int c);
        wait_neg(c - 1);
        @(posedge clk); #1;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic do_frame(input logic [2:0] ch, input logic sgl, input logic nul, input bit glitch);
        int    t0;
        vrec_t v;
        model_null = nul;
        wait_idle();
        @(posedge clk); #1;
        chan_i = ch; single_ended_i = sgl; start_i = 1'b1; t0 = cyc;
        @(posedge clk); #1;
        start_i = 1'b0; chan_i = 3'($urandom); single_ended_i = 1'($urandom);
        wait_neg(t0 + 1);
        check("busy_rise", 32'(busy_o), 32'd1);
        check("cs_low", 32'(cs_n_o), 32'd0);
        check("start_bit", 32'(mosi_o), 32'd1);
        if (glitch) begin
            pulse_at(t0 + 10);
            pulse_at(t0 + 60);
        end
        wait_neg(t0 + FRAME_LEN + GAP);
        check("busy_in_gap", 32'(busy_o), 32'd1);
        wait_neg(t0 + FRAME_LEN + GAP + 2);
        check("busy_drop", 32'(busy_o), 32'd0);
        wait_neg(t0 + 150);
        check("cs_idle", 32'(cs_n_o), 32'd1);
        check("data_hold", 32'(data_o), 32'(adc_val[ch]));
        check("valid_count", 32'(vq.size()), 32'd1);
        if (vq.size() > 0) begin
            v = vq.pop_front();
            check("valid_cycle", 32'(v.c), 32'(t0 + FRAME_LEN));
            check("data", 32'(v.d), 32'(adc_val[ch]));
            check("chan", 32'(v.ch), 32'(ch));
            check("null_err", 32'(v.n), 32'(nul));
            $display("frame t0=%0d ch=%0d sgl=%0d null=%0d data=%03h valid@%0d", t0, ch, sgl, nul, v.d, v.c);
        end
        check("cmd_bits", (cmd_q.size() > 0) ? 32'(cmd_q[0]) : 32'hFFFF_FFFF, 32'({1'b1, sgl, ch}));
        check("rise_count", (rise_q.size() > 0) ? 32'(rise_q[0]) : 32'hFFFF_FFFF, 32'd17);
        vq.delete(); cmd_q.delete(); rise_q.delete();
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    int         t0;
    logic [2:0] chs [3];

    initial begin : main
        for (int i = 0; i < 8; i++) adc_val[i] = 10'($urandom);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cs_n", 32'(cs_n_o), 32'd1);
        check("rst_sclk", 32'(sclk_o), 32'd0);
        check("rst_mosi", 32'(mosi_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_data", 32'(data_o), 32'd0);
        check("rst_chan", 32'(chan_o), 32'd0);
        check("rst_null", 32'(null_err_o), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Known values and channel patterns
        adc_val[0] = 10'h2A5;
        do_frame(3'd0, 1'b1, 1'b0, 1'b0);
        adc_val[5] = 10'h3FF;
        do_frame(3'd5, 1'b1, 1'b0, 1'b0);
        adc_val[2] = 10'h000;
        do_frame(3'd2, 1'b0, 1'b0, 1'b0);

        // Starts during a frame are ignored
        adc_val[6] = 10'($urandom);
        do_frame(3'd6, 1'b1, 1'b0, 1'b1);

        // Random frames
        for (int i = 0; i < 6; i++) begin
            logic [2:0] rc;
            rc = 3'($urandom);
            adc_val[rc] = 10'($urandom);
            do_frame(rc, 1'($urandom), 1'b0, 1'b0);
        end

        // start_i held high: back-to-back frames at the minimum period
        for (int i = 0; i < 3; i++) chs[i] = 3'($urandom);
        wait_idle();
        @(posedge clk); #1;
        chan_i = chs[0]; single_ended_i = 1'b1; start_i = 1'b1; t0 = cyc;
        wait_neg(t0 + 1);
        gap_q.delete();
        wait_neg(t0 + 20);
        chan_i = chs[1];
        wait_neg(t0 + PERIOD + 20);
        chan_i = chs[2];
        wait_neg(t0 + 2 * PERIOD + 5);
        start_i = 1'b0;
        wait_neg(t0 + 3 * PERIOD + 10);
        check("b2b_valid_count", 32'(vq.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (vq.size() > i) begin
                check("b2b_valid_cycle", 32'(vq[i].c), 32'(t0 + FRAME_LEN + i * PERIOD));
                check("b2b_data", 32'(vq[i].d), 32'(adc_val[chs[i]]));
                check("b2b_chan", 32'(vq[i].ch), 32'(chs[i]));
                $display("b2b frame %0d ch=%0d data=%03h valid@%0d", i, vq[i].ch, vq[i].d, vq[i].c);
            end
        end
        check("b2b_gap_count", 32'(gap_q.size()), 32'd2);
        for (int i = 0; i < gap_q.size(); i++) check("b2b_cs_gap", 32'(gap_q[i]), 32'(GAP + 2));
        check("b2b_cs_idle", 32'(cs_n_o), 32'd1);
        vq.delete(); cmd_q.delete(); rise_q.delete();

        // Null bit error, then a clean frame clears it
        adc_val[3] = 10'($urandom);
        do_frame(3'd3, 1'b1, 1'b1, 1'b0);
        do_frame(3'd3, 1'b0, 1'b0, 1'b0);

        // Reset asserted at rising edge 9, between clock edges
        model_null = 1'b0;
        wait_idle();
        @(posedge clk); #1;
        chan_i = 3'd4; single_ended_i = 1'b1; start_i = 1'b1; t0 = cyc;
        @(posedge clk); #1;
        start_i = 1'b0;
        wait_neg(t0 + 1 + SH + 16 * SH);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_cs_n", 32'(cs_n_o), 32'd1);
        check("abort_sclk", 32'(sclk_o), 32'd0);
        check("abort_busy", 32'(busy_o), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_neg(t0 + 160);
        check("abort_no_valid", 32'(vq.size()), 32'd0);
        check("abort_rises", (rise_q.size() > 0) ? 32'(rise_q[0]) : 32'hFFFF_FFFF, 32'd9);
        $display("abort t0=%0d reset at rising edge 9", t0);
        vq.delete(); cmd_q.delete(); rise_q.delete();
        adc_val[4] = 10'($urandom);
        do_frame(3'd4, 1'b1, 1'b0, 1'b0);

        check("mosi_rules", 32'(rule_viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
